// File: rtl/pipe.sv
// Parameterised shift-register delay line: LENGTH stages of WIDTH bits, async active-low reset.
// Optional macro PIPE_TAPS_EN adds a taps port exposing every stage.
module pipe #(
  parameter int unsigned      LENGTH    = 10,
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
`ifdef PIPE_TAPS_EN
  ,
  output logic [((LENGTH > 0) ? LENGTH : 1)*WIDTH-1:0] taps
`endif
);

  if (LENGTH == 0) begin : g_wire
    assign out = in;
`ifdef PIPE_TAPS_EN
    // No stages exist, so the taps bus has nothing to carry and is tied off.
    assign taps = '0;
`endif
  end else begin : g_regs
    // Packed so stage[k] lands at bits k*WIDTH, matching the taps layout.
    logic [LENGTH-1:0][WIDTH-1:0] stage;

    for (genvar k = 0; k < LENGTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) stage[k] <= RESET_VAL;
          else      stage[k] <= in;
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) stage[k] <= RESET_VAL;
          else      stage[k] <= stage[k-1];
        end
      end
    end

    assign out = stage[LENGTH-1];
`ifdef PIPE_TAPS_EN
    assign taps = stage;
`endif
  end

endmodule

// File: tb/tb_pipe.sv
// Directed bench for pipe: reset, pulses, data integrity, mid-flight reset, LENGTH 0/1 variants.
module tb_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in1 = 1'b0;
  logic [7:0] in8 = 8'h00;
  logic       out1;
  logic [7:0] out8, out0, out_l1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe #(.LENGTH(10), .WIDTH(1)) dut (.clk(clk), .rst(rst), .in(in1), .out(out1)
`ifdef PIPE_TAPS_EN
    , .taps()
`endif
  );
  pipe #(.LENGTH(10), .WIDTH(8)) dut8 (.clk(clk), .rst(rst), .in(in8), .out(out8)
`ifdef PIPE_TAPS_EN
    , .taps()
`endif
  );
  pipe #(.LENGTH(0), .WIDTH(8)) dut0 (.clk(clk), .rst(rst), .in(in8), .out(out0)
`ifdef PIPE_TAPS_EN
    , .taps()
`endif
  );
  pipe #(.LENGTH(1), .WIDTH(8)) dut_l1 (.clk(clk), .rst(rst), .in(in8), .out(out_l1)
`ifdef PIPE_TAPS_EN
    , .taps()
`endif
  );
`ifdef PIPE_TAPS_EN
  logic [7:0]  out_t;
  logic [31:0] taps_t;
  pipe #(.LENGTH(4), .WIDTH(8)) dut_t (.clk(clk), .rst(rst), .in(in8), .out(out_t), .taps(taps_t));
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in1 = 1'b1;
    in8 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (out1 !== 1'b0 || out8 !== 8'h00) begin
        fails++;
        $display("FAIL reset_edge cyc=%0d out1=%b out8=%h want 0/00", i, out1, out8);
      end
      @(negedge clk);
      tests++;
      if (out1 !== 1'b0 || out8 !== 8'h00) begin
        fails++;
        $display("FAIL reset_between cyc=%0d out1=%b out8=%h want 0/00", i, out1, out8);
      end
    end
    step();
    #2 rst = 1'b1;
    // Edges after release: the 10th edge is the first to show the captured 1.
    for (int k = 0; k < 10; k++) begin
      step();
      tests++;
      if (out1 !== (k == 9)) begin
        fails++;
        $display("FAIL reset_release edge=%0d out1=%b want %b", k, out1, (k == 9));
      end
    end
  endtask

  task automatic test_async_reset();
    in1 = 1'b1;
    for (int i = 0; i < 12; i++) step();
    tests++;
    if (out1 !== 1'b1) begin
      fails++;
      $display("FAIL async_prefill out1=%b want 1", out1);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (out1 !== 1'b0) begin
      fails++;
      $display("FAIL async_reset out1=%b want 0", out1);
    end
    step();
    in1 = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_single_pulse();
    in1 = 1'b1;
    step();
    in1 = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tests++;
      if (out1 !== (k == 9)) begin
        fails++;
        $display("FAIL single_pulse edge=n+%0d out1=%b want %b", k, out1, (k == 9));
      end
      step();
    end
  endtask

  task automatic test_wide_pulse();
    int ones = 0;
    in1 = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      in1 = (k < 6);
      if (out1 === 1'b1) ones++;
      tests++;
      if (out1 !== (k >= 9 && k <= 15)) begin
        fails++;
        $display("FAIL wide_pulse edge=n+%0d out1=%b want %b", k, out1, (k >= 9 && k <= 15));
      end
    end
    tests++;
    if (ones != 7) begin
      fails++;
      $display("FAIL wide_pulse_len got %0d cycles want 7", ones);
    end
  endtask

  task automatic test_data_integrity();
    for (int i = 0; i < 266; i++) begin
      in8 = (i < 256) ? 8'(i) : 8'h00;
      #1;
      tests++;
      if (out0 !== in8) begin
        fails++;
        $display("FAIL len0_comb i=%0d out=%h want %h", i, out0, in8);
      end
      step();
      if (i < 256) begin
        tests++;
        if (out_l1 !== 8'(i)) begin
          fails++;
          $display("FAIL len1_delay edge=%0d out=%h want %h", i, out_l1, 8'(i));
        end
      end
      if (i >= 9 && i < 265) begin
        tests++;
        if (out8 !== 8'(i - 9)) begin
          fails++;
          $display("FAIL data_integrity edge=%0d out=%h want %h", i, out8, 8'(i - 9));
        end
      end
`ifdef PIPE_TAPS_EN
      if (i >= 3 && i < 256) begin
        for (int k = 0; k < 4; k++) begin
          tests++;
          if (taps_t[k*8 +: 8] !== 8'(i - k)) begin
            fails++;
            $display("FAIL taps k=%0d edge=%0d got %h want %h", k, i, taps_t[k*8 +: 8], 8'(i - k));
          end
        end
      end
`endif
    end
  endtask

  task automatic test_midflight_reset();
    in1 = 1'b1;
    step();
    in1 = 1'b0;
    for (int k = 1; k < 5; k++) step();
    #2 rst = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      tests++;
      if (out1 !== 1'b0) begin
        fails++;
        $display("FAIL midflight_reset edge=%0d out1=%b want 0", k, out1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_single_pulse();
    test_wide_pulse();
    test_midflight_reset();
    test_data_integrity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
